id_issue_ctrl: RTL

Parametrised ID/EX issue controller for the pipelined core. It owns the ID/EX pipeline register and decides each cycle whether to issue the decoded instruction or inject a bubble. Bubble trains are configurable per instruction class (link, multi-cycle), and load-use hazards are detected internally. It honours a downstream hold and a branch flush, and drives the upstream stall for IF/ID.

---
 rtl/id_issue_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/id_issue_ctrl.sv
// ID/EX issue controller: owns the ID/EX pipeline register, inserts bubble trains
// after link and multi-cycle instructions, and stalls on load-use hazards.
module id_issue_ctrl #(
   parameter int PAYLOAD_W    = 64,
   parameter int REG_AW       = 5,
   parameter int LINK_BUBBLES = 2,
   parameter int MUL_BUBBLES  = 9,
   parameter int CNT_W        = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 hold,
   input  logic                 flush,
   input  logic                 id_valid,
   input  logic [PAYLOAD_W-1:0] id_payload,
   input  logic [1:0]           id_class,
   input  logic [REG_AW-1:0]    id_rs,
   input  logic [REG_AW-1:0]    id_rt,
   input  logic                 id_uses_rs,
   input  logic                 id_uses_rt,
   input  logic [REG_AW-1:0]    id_dest,
   input  logic                 id_dest_we,
   input  logic                 id_is_load,
   output logic                 ex_valid,
   output logic [PAYLOAD_W-1:0] ex_payload,
   output logic [REG_AW-1:0]    ex_dest,
   output logic                 ex_dest_we,
   output logic                 ex_is_load,
   output logic                 stall_if,
   output logic [CNT_W-1:0]     bubble_cnt
);

   // Handshake: the instruction in ID is consumed on an edge where hold=0 and
   // stall_if=0 (issued, or discarded if flush/id_valid=0); while stall_if=1 the
   // IF/ID stage must keep presenting the same instruction.

   // State is carried by bubble_cnt: zero means ISSUE, non-zero means DRAIN.
   typedef enum logic {ST_ISSUE, ST_DRAIN} state_t;

   state_t               state;
   logic                 lu_hazard;
   logic                 ex_valid_n;
   logic [PAYLOAD_W-1:0] ex_payload_n;
   logic [REG_AW-1:0]    ex_dest_n;
   logic                 ex_dest_we_n;
   logic                 ex_is_load_n;
   logic [CNT_W-1:0]     cnt_n;

   assign state = (bubble_cnt != '0) ? ST_DRAIN : ST_ISSUE;

   // Register 0 is hardwired, so a load targeting it never creates a dependency.
   assign lu_hazard = ex_valid & ex_is_load & ex_dest_we & (ex_dest != '0) & id_valid &
                      ((id_uses_rs & (id_rs == ex_dest)) | (id_uses_rt & (id_rt == ex_dest)));

   assign stall_if = hold | (~flush & ((state == ST_DRAIN) | lu_hazard));

   always_comb begin
      ex_valid_n   = ex_valid;
      ex_payload_n = ex_payload;
      ex_dest_n    = ex_dest;
      ex_dest_we_n = ex_dest_we;
      ex_is_load_n = ex_is_load;
      cnt_n        = bubble_cnt;
      if (!hold) begin
         ex_valid_n   = 1'b0;
         ex_payload_n = '0;
         ex_dest_n    = '0;
         ex_dest_we_n = 1'b0;
         ex_is_load_n = 1'b0;
         if (flush) begin
            cnt_n = '0;
         end else if (state == ST_DRAIN) begin
            cnt_n = bubble_cnt - CNT_W'(1);
         end else if (!lu_hazard && id_valid) begin
            ex_valid_n   = 1'b1;
            ex_payload_n = id_payload;
            ex_dest_n    = id_dest;
            ex_dest_we_n = id_dest_we;
            ex_is_load_n = id_is_load;
            case (id_class)
               2'b01:   cnt_n = CNT_W'(LINK_BUBBLES);
               2'b10:   cnt_n = CNT_W'(MUL_BUBBLES);
               default: cnt_n = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid   <= 1'b0;
         ex_payload <= '0;
         ex_dest    <= '0;
         ex_dest_we <= 1'b0;
         ex_is_load <= 1'b0;
         bubble_cnt <= '0;
      end else begin
         ex_valid   <= ex_valid_n;
         ex_payload <= ex_payload_n;
         ex_dest    <= ex_dest_n;
         ex_dest_we <= ex_dest_we_n;
         ex_is_load <= ex_is_load_n;
         bubble_cnt <= cnt_n;
      end
   end

endmodule
